fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h00000000, PC value loaded by reset; NOP, 32'h00000000, instruction word inserted as a bubble.
REQ-002 Ports SHALL be: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  hazard unit holds PC and IF/ID.
REQ-005 flush  in  1  replace IF/ID contents with a bubble.
REQ-006 PCSrc  in  1  redirect fetch to BranchTarget.
REQ-007 BranchTarget  in  32  word address of redirect target.
REQ-008 ImemReq  out  1  instruction-memory read request.
REQ-009 ImemAddr  out  32  word address of request, equals PC.
REQ-010 ImemAck  in  1  memory returns ImemData this cycle.
REQ-011 ImemData  in  32  fetched instruction word.
REQ-012 PC  out  32  current program counter (word address).
REQ-013 IF_ID_Instr  out  32; IF_ID_NPC  out  32; IF_ID_Valid  out  1  IF/ID pipeline register.

Function
REQ-014 PC SHALL be word-addressed; sequential next PC = PC + 1, modulo 2^32 (32'hFFFFFFFF wraps to 0).
REQ-015 State machine SHALL have states FETCH, HELD, DISCARD.
REQ-016 FETCH: ImemReq=1, ImemAddr=PC; ImemAddr SHALL stay stable while ImemReq=1 and ImemAck=0.
REQ-017 FETCH, ImemAck=1, stall=0, PCSrc=0: IF/ID <= {ImemData, PC+1, 1}; PC <= PC+1; remain FETCH; one instruction per cycle with single-cycle memory.
REQ-018 FETCH, ImemAck=1, stall=1, PCSrc=0: ImemData SHALL be captured in a one-entry hold buffer, PC and IF/ID unchanged, go HELD.
REQ-019 HELD: ImemReq=0; when stall=0, IF/ID <= {buffer, PC+1, 1}, PC <= PC+1, go FETCH.
REQ-020 PCSrc=1 in FETCH with ImemAck=1, or in HELD: PC <= BranchTarget, fetched/buffered word dropped, IF/ID <= bubble, go FETCH; PCSrc SHALL override stall.
REQ-021 PCSrc=1 in FETCH with ImemAck=0: BranchTarget SHALL be latched as pending redirect, go DISCARD; PC output unchanged.
REQ-022 DISCARD: ImemReq=1 with the old address until ImemAck; on ImemAck data dropped, PC <= pending target, IF/ID <= bubble, go FETCH; a later PCSrc in DISCARD SHALL overwrite the pending target.
REQ-023 Bubble SHALL be IF_ID_Instr=NOP, IF_ID_NPC=0, IF_ID_Valid=0.
REQ-024 flush=1 SHALL force IF/ID to bubble at the next edge, overriding stall and any capture that cycle; PC behaviour unaffected by flush.
REQ-025 stall=1 without PCSrc SHALL hold IF/ID and PC unchanged (unless flush).
REQ-026 ImemAck while ImemReq=0 SHALL be ignored.

Reset
REQ-027 rst=1 at a rising edge SHALL set PC=RESET_PC, IF/ID=bubble, state=FETCH, clear hold buffer and pending redirect, with priority over all other inputs.
REQ-028 ImemReq SHALL be 0 during any cycle rst=1 and SHALL assert in the first cycle after rst deasserts.
REQ-029 Reset mid-request SHALL abandon the outstanding request; a late ImemAck arriving in the reset cycle SHALL be ignored.

Verification
REQ-030 Release rst, ImemAck=1 every cycle, ImemData=32'h20080000+addr -> ImemAddr 0,1,2,3; IF_ID_NPC 1,2,3,4; IF_ID_Valid=1 from second cycle.
REQ-031 RESET_PC=32'hFFFFFFFE, continuous ack -> PC 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1; IF_ID_NPC after 32'hFFFFFFFF fetch = 0.
REQ-032 PC=5, stall=1 for 3 cycles coincident with ack of 32'hAABBCCDD -> PC stays 5, ImemReq=0 while HELD; stall drop -> IF_ID_Instr=32'hAABBCCDD, NPC=6, PC=6.
REQ-033 PC=8, ack delayed 3 cycles, PCSrc=1 with BranchTarget=32'h40 in first wait cycle -> ImemAddr stays 8 until ack, then IF_ID_Valid=0, next ImemAddr=32'h40.
REQ-034 stall=1 and flush=1 together with valid IF/ID -> IF_ID_Valid=0, IF_ID_Instr=NOP, PC unchanged.
REQ-035 rst=1 asserted while ImemReq=1 awaiting ack, ack arrives same cycle -> PC=RESET_PC, IF_ID_Valid=0, ImemReq=0 that cycle, 1 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, single-outstanding imem request,
// one-entry hold buffer for stalls, deferred redirect while a request is open,
// and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_NPC,
    output logic        IF_ID_Valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HELD    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   hold_q;
    logic [XLEN-1:0]   pend_q;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   npc_q;
    logic              valid_q;
    logic [XLEN-1:0]   pc_inc;

    // Sequential successor, wraps naturally at 2^32.
    assign pc_inc = pc_q + XLEN'(1);

    // Request is a registered state decode, forced low while reset is applied
    // so an in-flight request is dropped in the reset cycle itself.
    assign ImemReq     = ~rst & (state_q != HELD);
    assign ImemAddr    = pc_q;
    assign PC          = pc_q;
    assign IF_ID_Instr = instr_q;
    assign IF_ID_NPC   = npc_q;
    assign IF_ID_Valid = valid_q;

    // Fetch FSM, PC, hold buffer, pending redirect and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            pend_q  <= '0;
            instr_q <= NOP;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ImemAck) begin
                        if (PCSrc) begin
                            pc_q    <= BranchTarget;
                            instr_q <= NOP;
                            npc_q   <= '0;
                            valid_q <= 1'b0;
                        end else if (stall) begin
                            hold_q  <= ImemData;
                            state_q <= HELD;
                        end else begin
                            instr_q <= ImemData;
                            npc_q   <= pc_inc;
                            valid_q <= 1'b1;
                            pc_q    <= pc_inc;
                        end
                    end else if (PCSrc) begin
                        // Request still open: remember target, keep address stable.
                        pend_q  <= BranchTarget;
                        state_q <= DISCARD;
                    end
                end
                HELD: begin
                    if (PCSrc) begin
                        pc_q    <= BranchTarget;
                        instr_q <= NOP;
                        npc_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (!stall) begin
                        instr_q <= hold_q;
                        npc_q   <= pc_inc;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc;
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (ImemAck) begin
                        // Newest redirect wins if it arrives with the ack.
                        pc_q    <= PCSrc ? BranchTarget : pend_q;
                        instr_q <= NOP;
                        npc_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (PCSrc) begin
                        pend_q <= BranchTarget;
                    end
                end
                default: state_q <= FETCH;
            endcase

            // Flush overrides any IF/ID update made above this cycle.
            if (flush) begin
                instr_q <= NOP;
                npc_q   <= '0;
                valid_q <= 1'b0;
            end
        end
    end

endmodule
